inst_mem_prefetch: RTL and testbench

INST_MEM_PREFETCH -- requirements
Module: inst_mem_prefetch

---
 rtl/inst_mem_prefetch_pkg.sv | 20 ++
 rtl/inst_prefetch_queue.sv | 60 ++++++
 rtl/inst_mem_prefetch.sv | 133 +++++++++++++
 tb/tb_inst_mem_prefetch.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_prefetch_pkg.sv
// Shared definitions for the instruction memory prefetcher: fetch FSM
// states, the word pushed for faulting fetches, and the fault predicate.
package inst_mem_prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } fetch_state_e;

    // Instruction word delivered with a fault entry.
    localparam int unsigned FAULT_NOP = 0;

    // A fetch address faults when it is not word aligned or lies past the
    // end of the instruction memory.
    function automatic logic pc_faults(input logic [31:0] pc, input int depth);
        return (pc[1:0] != 2'b00) || ({2'b00, pc[31:2]} >= $unsigned(depth));
    endfunction

endpackage

// File: rtl/inst_prefetch_queue.sv
// Power-of-two FIFO holding prefetched entries. Pointers wrap naturally;
// a push is accepted when full only if the head is popped in the same cycle.
module inst_prefetch_queue #(
    parameter int W     = 32,
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic [W-1:0]  push_data_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Storage, pointers and occupancy; flush empties without touching storage.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/inst_mem_prefetch.sv
// Instruction memory with a sequential prefetcher. Fetches are issued into a
// one-stage synchronous read pipeline and land in a small queue presented as
// a valid/ready stream. Faulting addresses travel through the same pipeline
// stage so ordering against real reads is preserved.
module inst_mem_prefetch #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int Q_DEPTH = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              CLk,
    input  logic              Reset,
    input  logic              load_en,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc,
    input  logic              instr_ready,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr,
    output logic [31:0]       instr_pc,
    output logic              instr_fault
);

    import inst_mem_prefetch_pkg::*;

    localparam int CW = $clog2(Q_DEPTH) + 1;
    localparam int EW = DATA_W + 33;

    fetch_state_e      state_q;
    logic [31:0]       fetch_pc_q;
    logic [31:0]       fetch_pc_d;
    logic              rd_valid_q;
    logic              rd_fault_q;
    logic [31:0]       rd_pc_q;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_rd_q;

    logic              fetching;
    logic [31:0]       issue_pc;
    logic [CW:0]       occ;
    logic              slot_free;
    logic              issue;
    logic              issue_fault;
    logic              issue_rd;

    logic              q_push;
    logic [EW-1:0]     q_push_data;
    logic              q_pop;
    logic [EW-1:0]     q_head;
    logic [CW-1:0]     q_count;
    logic              q_full;
    logic              q_empty;

    // Issue decision: a redirect restarts at redirect_pc against an empty
    // queue; otherwise queued plus in-flight entries must leave a free slot.
    always_comb begin
        fetching    = redirect || (state_q == ST_FETCH);
        issue_pc    = redirect ? redirect_pc : fetch_pc_q;
        occ         = {1'b0, q_count} + {{CW{1'b0}}, rd_valid_q};
        slot_free   = redirect || (!q_full && (occ < (CW + 1)'(Q_DEPTH)));
        issue       = fetching && !load_en && slot_free;
        issue_fault = issue && pc_faults(issue_pc, DEPTH);
        issue_rd    = issue && !issue_fault;
        fetch_pc_d  = issue ? issue_pc + 32'd4 : issue_pc;
    end

    // Program load has the port; the fetch read is simply not issued that cycle.
    always_ff @(posedge CLk) begin
        if (load_en) begin
            mem_q[load_addr] <= load_data;
        end
        if (issue_rd) begin
            mem_rd_q <= mem_q[issue_pc[AW+1:2]];
        end
    end

    // Fetch FSM, fetch pointer and the read pipeline stage.
    always_ff @(posedge CLk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= '0;
            rd_valid_q <= 1'b0;
            rd_fault_q <= 1'b0;
            rd_pc_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_valid_q <= issue;
            rd_fault_q <= issue_fault;
            rd_pc_q    <= issue_pc;
            unique case (state_q)
                ST_IDLE, ST_HALT: begin
                    if (redirect) begin
                        state_q <= issue_fault ? ST_HALT : ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (issue_fault) begin
                        state_q <= ST_HALT;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A read completing in a redirect cycle belongs to the old stream.
    assign q_push      = rd_valid_q && !redirect;
    assign q_push_data = {rd_fault_q, rd_pc_q, rd_fault_q ? DATA_W'(FAULT_NOP) : mem_rd_q};
    assign q_pop       = instr_valid && instr_ready && !redirect;

    inst_prefetch_queue #(
        .W     (EW),
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clk_i       (CLk),
        .rst_i       (Reset),
        .flush_i     (redirect),
        .push_i      (q_push),
        .push_data_i (q_push_data),
        .pop_i       (q_pop),
        .head_o      (q_head),
        .count_o     (q_count),
        .full_o      (q_full),
        .empty_o     (q_empty)
    );

    assign instr_valid = !q_empty;
    assign instr       = q_head[DATA_W-1:0];
    assign instr_pc    = q_head[DATA_W+31:DATA_W];
    assign instr_fault = q_head[EW-1];

endmodule

// File: tb/tb_inst_mem_prefetch.sv
// Bench for inst_mem_prefetch: a stream model (expected next pc, memory
// image) checks every accepted entry; directed phases pin literal values.
module tb_inst_mem_prefetch;

    localparam int DATA_W  = 32;
    localparam int DEPTH   = 256;
    localparam int Q_DEPTH = 4;

    logic        CLk = 1'b0;
    logic        Reset = 1'b0;
    logic        load_en = 1'b0;
    logic [7:0]  load_addr = '0;
    logic [31:0] load_data = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_ready = 1'b0;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    always #5 CLk = ~CLk;

    inst_mem_prefetch #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .Q_DEPTH (Q_DEPTH)
    ) dut (
        .CLk         (CLk),
        .Reset       (Reset),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_fault (instr_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
        logic        fault;
    } ent_t;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_model [DEPTH];
    ent_t        hs_log [$];

    bit          exp_active = 1'b0;
    logic [31:0] exp_pc = '0;
    bit          after_redir = 1'b0;
    bit          prev_hold = 1'b0;
    logic [31:0] p_instr = '0;
    logic [31:0] p_pc = '0;
    logic        p_fault = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit is_fault(input logic [31:0] pc);
        return (pc[1:0] != 2'b00) || ((pc >> 2) >= 32'(DEPTH));
    endfunction

    function automatic ent_t log_at(input int k);
        ent_t e;
        e.pc = 32'hDEAD_DEAD;
        e.data = 32'hDEAD_DEAD;
        e.fault = 1'b1;
        if (hs_log.size() > k) e = hs_log[k];
        return e;
    endfunction

    // Stream model: after a redirect to P the accepted entries must be
    // P, P+4, ... with current memory contents, ending at the first fault.
    always @(negedge CLk) begin
        if (Reset) begin
            chk("reset_valid", instr_valid, 0);
            chk("reset_instr", instr, 0);
            chk("reset_pc", instr_pc, 0);
            chk("reset_fault", instr_fault, 0);
            exp_active  = 1'b0;
            after_redir = 1'b0;
            prev_hold   = 1'b0;
        end else begin
            if (after_redir) begin
                chk("valid_after_redirect", instr_valid, 0);
                after_redir = 1'b0;
            end
            if (prev_hold) begin
                chk("hold_valid", instr_valid, 1);
                chk("hold_instr", instr, p_instr);
                chk("hold_pc", instr_pc, p_pc);
                chk("hold_fault", instr_fault, p_fault);
            end
            chk("spurious_valid", instr_valid && !exp_active, 0);
            if (instr_valid && instr_ready && !redirect && exp_active) begin
                if (is_fault(exp_pc)) begin
                    chk("hs_fault", instr_fault, 1);
                    chk("hs_instr", instr, 0);
                    chk("hs_pc", instr_pc, exp_pc);
                    exp_active = 1'b0;
                end else begin
                    chk("hs_fault", instr_fault, 0);
                    chk("hs_instr", instr, mem_model[exp_pc[9:2]]);
                    chk("hs_pc", instr_pc, exp_pc);
                    exp_pc = exp_pc + 32'd4;
                end
                hs_log.push_back('{instr_pc, instr, instr_fault});
            end
            prev_hold = instr_valid && !instr_ready && !redirect;
            p_instr   = instr;
            p_pc      = instr_pc;
            p_fault   = instr_fault;
            if (redirect) begin
                exp_active  = 1'b1;
                exp_pc      = redirect_pc;
                after_redir = 1'b1;
                prev_hold   = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge CLk);
        #1;
    endtask

    task automatic do_redirect(input logic [31:0] pc);
        redirect    = 1'b1;
        redirect_pc = pc;
        tick();
        redirect    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        ent_t e;
        #1 Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        tick();

        // Program load
        for (int i = 0; i < DEPTH; i++) begin
            load_en      = 1'b1;
            load_addr    = 8'(i);
            load_data    = (i < 8) ? 32'h1000_0000 + 32'(i) : 32'hA000_0000 + 32'(i);
            mem_model[i] = load_data;
            tick();
        end
        load_en = 1'b0;
        tick();
        chk("idle_valid", instr_valid, 0);

        // Linear stream from 0x0, first entry two cycles after redirect
        instr_ready = 1'b1;
        hs_log.delete();
        redirect    = 1'b1;
        redirect_pc = 32'h0;
        @(negedge CLk);
        chk("lat_c0", instr_valid, 0);
        @(posedge CLk);
        #1 redirect = 1'b0;
        @(negedge CLk);
        chk("lat_c1", instr_valid, 0);
        @(posedge CLk);
        @(negedge CLk);
        chk("lat_c2", instr_valid, 1);
        repeat (8) tick();
        chk("lin_count", hs_log.size(), 8);
        e = log_at(0);
        chk("lin_pc0", e.pc, 32'h0);
        chk("lin_d0", e.data, 32'h1000_0000);
        e = log_at(7);
        chk("lin_pc7", e.pc, 32'h1C);
        chk("lin_d7", e.data, 32'h1000_0007);

        // Backpressure: queue fills, word 4 rewritten while full must read new
        instr_ready = 1'b0;
        hs_log.delete();
        do_redirect(32'h0);
        repeat (5) tick();
        load_en      = 1'b1;
        load_addr    = 8'd4;
        load_data    = 32'hBEEF_0004;
        mem_model[4] = 32'hBEEF_0004;
        tick();
        load_en = 1'b0;
        repeat (2) tick();
        @(negedge CLk);
        chk("full_valid", instr_valid, 1);
        chk("full_pc", instr_pc, 32'h0);
        chk("full_instr", instr, 32'h1000_0000);
        @(posedge CLk);
        #1 instr_ready = 1'b1;
        repeat (12) tick();
        e = log_at(3);
        chk("bp_d3", e.data, 32'h1000_0003);
        e = log_at(4);
        chk("bp_pc4", e.pc, 32'h10);
        chk("bp_d4", e.data, 32'hBEEF_0004);

        // Misaligned redirect -> single fault entry
        hs_log.delete();
        do_redirect(32'h2);
        repeat (10) tick();
        chk("mis_count", hs_log.size(), 1);
        e = log_at(0);
        chk("mis_pc", e.pc, 32'h2);
        chk("mis_fault", e.fault, 1);
        chk("mis_instr", e.data, 0);

        // Run off the end of memory
        hs_log.delete();
        do_redirect(32'h3F8);
        repeat (10) tick();
        chk("end_count", hs_log.size(), 3);
        e = log_at(0);
        chk("end_d0", e.data, 32'hA000_00FE);
        e = log_at(1);
        chk("end_d1", e.data, 32'hA000_00FF);
        e = log_at(2);
        chk("end_pc2", e.pc, 32'h400);
        chk("end_fault2", e.fault, 1);

        // Redirect while entries queued; same-cycle pop is ignored
        hs_log.delete();
        do_redirect(32'h0);
        tick();
        do_redirect(32'h40);
        repeat (10) tick();
        e = log_at(0);
        chk("rr_pc0", e.pc, 32'h40);
        chk("rr_d0", e.data, 32'hA000_0010);

        // Interleaved loads during fetch, then reset mid-stream
        hs_log.delete();
        do_redirect(32'h0);
        for (int k = 0; k < 16; k++) begin
            if (k % 2 == 1) begin
                load_en            = 1'b1;
                load_addr          = 8'(128 + k);
                load_data          = 32'h5500_0000 + 32'(k);
                mem_model[128 + k] = load_data;
            end else begin
                load_en = 1'b0;
            end
            tick();
        end
        load_en = 1'b0;
        tick();
        chk("ld_enough", hs_log.size() >= 8, 1);
        e = log_at(2);
        chk("ld_pc2", e.pc, 32'h8);
        chk("ld_d2", e.data, 32'h1000_0002);
        Reset = 1'b1;
        repeat (2) tick();
        Reset = 1'b0;
        repeat (4) tick();
        chk("post_reset_valid", instr_valid, 0);
        hs_log.delete();
        do_redirect(32'h200);
        repeat (10) tick();
        e = log_at(0);
        chk("ret_pc0", e.pc, 32'h200);
        chk("ret_d0", e.data, 32'hA000_0080);
        e = log_at(1);
        chk("ret_pc1", e.pc, 32'h204);
        chk("ret_d1", e.data, 32'h5500_0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
